// File: rtl/control_unit_fft_iter_addr_gen.sv
// Address generator for an iterative radix-2 in-place DIT FFT. It tracks the layer and
// butterfly counters, decodes the read and twiddle addresses, and delays them for write-back.
module control_unit_fft_iter_addr_gen #(
    parameter int LAYERS      = 5,
    parameter int BUTTERFLYES = 16,
    parameter int LayWL       = 3,
    parameter int ButtWL      = 4,
    parameter int WR_DELAY    = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              ADDR_RST,
    input  logic              ADDR_EN,
    input  logic              LAY_EN,
    output logic [LAYERS-1:0] RD_ADDR_A,
    output logic [LAYERS-1:0] RD_ADDR_B,
    output logic [ButtWL-1:0] TW_ADDR,
    output logic [LAYERS-1:0] WR_ADDR_A,
    output logic [LAYERS-1:0] WR_ADDR_B,
    output logic              WR_VALID,
    output logic [LayWL-1:0]  LAY_CNT,
    output logic              LAST_BUT,
    output logic              LAST_LAYER
);

    localparam logic [LayWL-1:0]  S_MAX = LayWL'(LAYERS - 1);
    localparam logic [ButtWL-1:0] J_MAX = ButtWL'(BUTTERFLYES - 1);

    logic [LayWL-1:0]  lay_s;
    logic [ButtWL-1:0] but_j;

    logic [LAYERS-1:0] addr_a_p [WR_DELAY];
    logic [LAYERS-1:0] addr_b_p [WR_DELAY];
    logic              vld_p    [WR_DELAY];

    // Open a zero at bit s: bits below s stay put, bits at/above s move up by one.
    function automatic logic [LAYERS-1:0] insert_zero(input logic [ButtWL-1:0] j,
                                                      input logic [LayWL-1:0]  s);
        logic [LAYERS-1:0] ext;
        logic [LAYERS-1:0] low_mask;
        ext      = LAYERS'(j);
        low_mask = (LAYERS'(1) << s) - LAYERS'(1);
        return ((ext & ~low_mask) << 1) | (ext & low_mask);
    endfunction

    function automatic logic [ButtWL-1:0] tw_index(input logic [ButtWL-1:0] j,
                                                   input logic [LayWL-1:0]  s);
        logic [ButtWL-1:0] low_mask;
        low_mask = (ButtWL'(1) << s) - ButtWL'(1);
        return (j & low_mask) << (S_MAX - s);
    endfunction

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lay_s <= '0;
            but_j <= '0;
        end else if (EN) begin
            if (ADDR_RST) begin
                lay_s <= '0;
                but_j <= '0;
            end else if (LAY_EN) begin
                but_j <= '0;
                lay_s <= (lay_s == S_MAX) ? '0 : lay_s + LayWL'(1);
            end else if (ADDR_EN) begin
                but_j <= (but_j == J_MAX) ? '0 : but_j + ButtWL'(1);
            end
        end
    end

    assign RD_ADDR_A = insert_zero(but_j, lay_s);
    assign RD_ADDR_B = RD_ADDR_A | (LAYERS'(1) << lay_s);
    assign TW_ADDR   = tw_index(but_j, lay_s);

    // Write-back delay line: stage 0 takes the addresses being read this cycle.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < WR_DELAY; i++) begin
                addr_a_p[i] <= '0;
                addr_b_p[i] <= '0;
                vld_p[i]    <= 1'b0;
            end
        end else if (EN) begin
            addr_a_p[0] <= RD_ADDR_A;
            addr_b_p[0] <= RD_ADDR_B;
            vld_p[0]    <= ADDR_EN;
            for (int i = 1; i < WR_DELAY; i++) begin
                addr_a_p[i] <= addr_a_p[i-1];
                addr_b_p[i] <= addr_b_p[i-1];
                vld_p[i]    <= vld_p[i-1];
            end
        end
    end

    assign WR_ADDR_A  = addr_a_p[WR_DELAY-1];
    assign WR_ADDR_B  = addr_b_p[WR_DELAY-1];
    assign WR_VALID   = vld_p[WR_DELAY-1];

    assign LAY_CNT    = lay_s;
    assign LAST_BUT   = (but_j == J_MAX);
    assign LAST_LAYER = (lay_s == S_MAX);

endmodule

// File: tb/tb_control_unit_fft_iter_addr_gen.sv
// Directed bench for the FFT address generator; write-back addresses are
// checked through a scoreboard queue filled at issue time.
module tb_control_unit_fft_iter_addr_gen;

    localparam int LAYERS      = 5;
    localparam int BUTTERFLYES = 16;
    localparam int LayWL       = 3;
    localparam int ButtWL      = 4;
    localparam int WR_DELAY    = 4;

    logic              CLK;
    logic              RST;
    logic              EN;
    logic              ADDR_RST;
    logic              ADDR_EN;
    logic              LAY_EN;
    logic [LAYERS-1:0] RD_ADDR_A;
    logic [LAYERS-1:0] RD_ADDR_B;
    logic [ButtWL-1:0] TW_ADDR;
    logic [LAYERS-1:0] WR_ADDR_A;
    logic [LAYERS-1:0] WR_ADDR_B;
    logic              WR_VALID;
    logic [LayWL-1:0]  LAY_CNT;
    logic              LAST_BUT;
    logic              LAST_LAYER;

    control_unit_fft_iter_addr_gen #(
        .LAYERS(LAYERS), .BUTTERFLYES(BUTTERFLYES), .LayWL(LayWL),
        .ButtWL(ButtWL), .WR_DELAY(WR_DELAY)
    ) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .ADDR_RST(ADDR_RST), .ADDR_EN(ADDR_EN),
        .LAY_EN(LAY_EN), .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B),
        .TW_ADDR(TW_ADDR), .WR_ADDR_A(WR_ADDR_A), .WR_ADDR_B(WR_ADDR_B),
        .WR_VALID(WR_VALID), .LAY_CNT(LAY_CNT), .LAST_BUT(LAST_BUT),
        .LAST_LAYER(LAST_LAYER)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [LAYERS-1:0] a;
        logic [LAYERS-1:0] b;
        int                iss;
    } ent_t;

    ent_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   ms = 0;
    int   mj = 0;
    int   en_edges = 0;
    int   wr_pulses = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic logic [LAYERS-1:0] model_a(input int s, input int j);
        logic [LAYERS-1:0] r;
        int k;
        r = '0;
        k = 0;
        for (int i = 0; i < LAYERS; i++) begin
            if (i != s) begin
                r[i] = ((j >> k) & 1) != 0;
                k++;
            end
        end
        return r;
    endfunction

    function automatic int model_tw(input int s, input int j);
        return ((j % (1 << s)) << (LAYERS - 1 - s)) & ((1 << ButtWL) - 1);
    endfunction

    task automatic check_rd();
        chk("rd_addr_a", 32'(RD_ADDR_A), 32'(model_a(ms, mj)));
        chk("rd_addr_b", 32'(RD_ADDR_B), 32'(model_a(ms, mj) | (LAYERS'(1) << ms)));
        chk("tw_addr", 32'(TW_ADDR), 32'(model_tw(ms, mj)));
        chk("lay_cnt", 32'(LAY_CNT), 32'(ms));
        chk("last_but", 32'(LAST_BUT), 32'(mj == BUTTERFLYES - 1));
        chk("last_layer", 32'(LAST_LAYER), 32'(ms == LAYERS - 1));
    endtask

    task automatic check_wr();
        logic due;
        due = (sb.size() > 0) && (en_edges - sb[0].iss == WR_DELAY - 1);
        chk("wr_valid", 32'(WR_VALID), 32'(due));
        if (WR_VALID === 1'b1) wr_pulses++;
        if (due) begin
            chk("wr_addr_a", 32'(WR_ADDR_A), 32'(sb[0].a));
            chk("wr_addr_b", 32'(WR_ADDR_B), 32'(sb[0].b));
            void'(sb.pop_front());
        end
    endtask

    task automatic step(input logic en, input logic ar, input logic ae, input logic le);
        ent_t e;
        EN = en; ADDR_RST = ar; ADDR_EN = ae; LAY_EN = le;
        if (en && ae) begin
            e.a   = model_a(ms, mj);
            e.b   = model_a(ms, mj) | (LAYERS'(1) << ms);
            e.iss = en_edges + 1;
            sb.push_back(e);
        end
        @(posedge CLK);
        #1;
        if (en) begin
            en_edges++;
            if (ar) begin
                ms = 0; mj = 0;
            end else if (le) begin
                mj = 0; ms = (ms + 1) % LAYERS;
            end else if (ae) begin
                mj = (mj + 1) % BUTTERFLYES;
            end
        end
        check_rd();
        if (en) check_wr();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_a"}, 32'(RD_ADDR_A), 32'd0);
        chk({tag, "_rd_b"}, 32'(RD_ADDR_B), 32'd1);
        chk({tag, "_tw"}, 32'(TW_ADDR), 32'd0);
        chk({tag, "_wr_a"}, 32'(WR_ADDR_A), 32'd0);
        chk({tag, "_wr_b"}, 32'(WR_ADDR_B), 32'd0);
        chk({tag, "_wr_valid"}, 32'(WR_VALID), 32'd0);
        chk({tag, "_lay_cnt"}, 32'(LAY_CNT), 32'd0);
        chk({tag, "_last_but"}, 32'(LAST_BUT), 32'd0);
        chk({tag, "_last_layer"}, 32'(LAST_LAYER), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hits [2**LAYERS];
        int once;

        RST = 1'b0; EN = 1'b0; ADDR_RST = 1'b0; ADDR_EN = 1'b0; LAY_EN = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        RST = 1'b1;

        // Idle enabled cycles hold the reset addresses
        repeat (3) step(1, 0, 0, 0);
        chk("idle_wr_valid", 32'(WR_VALID), 32'd0);

        repeat (3) step(1, 0, 1, 0);
        chk("j3_rd_a", 32'(RD_ADDR_A), 32'd6);
        chk("j3_rd_b", 32'(RD_ADDR_B), 32'd7);
        chk("j3_tw", 32'(TW_ADDR), 32'd0);
        repeat (WR_DELAY) step(1, 0, 0, 0);

        // Single issue at 6/7, stretched by two EN-low cycles
        step(1, 0, 1, 0); chk("lat_c1", 32'(WR_VALID), 32'd0);
        step(1, 0, 0, 0); chk("lat_c2", 32'(WR_VALID), 32'd0);
        step(0, 0, 0, 0); chk("lat_c3", 32'(WR_VALID), 32'd0);
        step(0, 0, 0, 0); chk("lat_c4", 32'(WR_VALID), 32'd0);
        step(1, 0, 0, 0); chk("lat_c5", 32'(WR_VALID), 32'd0);
        step(1, 0, 0, 0);
        chk("lat_c6_valid", 32'(WR_VALID), 32'd1);
        chk("lat_c6_wr_a", 32'(WR_ADDR_A), 32'd6);
        chk("lat_c6_wr_b", 32'(WR_ADDR_B), 32'd7);
        step(1, 0, 0, 0); chk("lat_c7", 32'(WR_VALID), 32'd0);

        repeat (11) step(1, 0, 1, 0);
        chk("j15_last_but", 32'(LAST_BUT), 32'd1);
        chk("j15_rd_a", 32'(RD_ADDR_A), 32'd30);
        step(1, 0, 1, 0);
        chk("jwrap_last_but", 32'(LAST_BUT), 32'd0);
        chk("jwrap_rd_a", 32'(RD_ADDR_A), 32'd0);
        chk("jwrap_lay_cnt", 32'(LAY_CNT), 32'd0);

        step(1, 0, 0, 1); step(1, 0, 0, 1);
        repeat (5) step(1, 0, 1, 0);
        chk("s2j5_rd_a", 32'(RD_ADDR_A), 32'd9);
        chk("s2j5_rd_b", 32'(RD_ADDR_B), 32'd13);
        chk("s2j5_tw", 32'(TW_ADDR), 32'd4);
        chk("s2j5_lay_cnt", 32'(LAY_CNT), 32'd2);

        step(1, 0, 0, 1); step(1, 0, 0, 1);
        repeat (15) step(1, 0, 1, 0);
        chk("s4j15_rd_a", 32'(RD_ADDR_A), 32'd15);
        chk("s4j15_rd_b", 32'(RD_ADDR_B), 32'd31);
        chk("s4j15_tw", 32'(TW_ADDR), 32'd15);
        chk("s4j15_last_but", 32'(LAST_BUT), 32'd1);
        chk("s4j15_last_layer", 32'(LAST_LAYER), 32'd1);
        step(1, 0, 1, 1);
        chk("laywrap_lay_cnt", 32'(LAY_CNT), 32'd0);
        chk("laywrap_rd_a", 32'(RD_ADDR_A), 32'd0);
        chk("laywrap_last_layer", 32'(LAST_LAYER), 32'd0);

        // EN low must ignore every strobe
        step(1, 0, 1, 0); step(1, 0, 1, 0);
        step(0, 1, 1, 1);
        chk("en_low_rd_a", 32'(RD_ADDR_A), 32'd4);

        // ADDR_RST wins over LAY_EN and leaves in-flight writes draining
        step(1, 0, 0, 1);
        step(1, 0, 1, 0);
        step(1, 1, 1, 1);
        chk("addr_rst_lay_cnt", 32'(LAY_CNT), 32'd0);
        chk("addr_rst_rd_a", 32'(RD_ADDR_A), 32'd0);
        repeat (WR_DELAY) step(1, 0, 0, 0);
        chk("addr_rst_drained", 32'(sb.size()), 32'd0);

        // Full transform sweep
        step(1, 1, 0, 0);
        wr_pulses = 0;
        for (int l = 0; l < LAYERS; l++) begin
            for (int k = 0; k < 2**LAYERS; k++) hits[k] = 0;
            for (int b = 0; b < BUTTERFLYES; b++) begin
                hits[RD_ADDR_A]++;
                hits[RD_ADDR_B]++;
                step(1, 0, 1, (b == BUTTERFLYES - 1) ? 1'b1 : 1'b0);
            end
            once = 0;
            for (int k = 0; k < 2**LAYERS; k++) if (hits[k] == 1) once++;
            chk("layer_cover", 32'(once), 32'(2**LAYERS));
        end
        repeat (WR_DELAY) step(1, 0, 0, 0);
        chk("sweep_wr_pulses", 32'(wr_pulses), 32'd80);
        chk("sweep_lay_wrap", 32'(LAY_CNT), 32'd0);

        // Async reset mid-transform with writes in flight
        repeat (3) step(1, 0, 1, 0);
        #2;
        RST = 1'b0;
        #1;
        check_reset_outputs("async");
        sb.delete();
        ms = 0; mj = 0;
        @(posedge CLK);
        #1;
        chk("async_hold_wr_valid", 32'(WR_VALID), 32'd0);
        RST = 1'b1;
        repeat (WR_DELAY + 1) step(1, 0, 0, 0);
        chk("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
